// File: rtl/sram_like_pkg.sv
// sram_like_pkg: size encodings, the queued-request record and the
// byte-lane helper shared by the slave and its request queue.
package sram_like_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Everything needed to complete a request, captured at acceptance
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_entry_t;

   // Byte enables for a write of the given size at byte offset lo;
   // size 3 is treated as a full word
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << lo;
         SZ_HALF: be = 4'b0011 << {lo[1], 1'b0};
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sram_like_slave_req_fifo.sv
// req_fifo: synchronous in-order FIFO of request records. Push is ignored
// when full and pop when empty, so callers may gate loosely.
module req_fifo
   import sram_like_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       push_i,
   input  logic       pop_i,
   input  req_entry_t din_i,
   output logic       full_o,
   output logic       empty_o,
   output req_entry_t head_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   req_entry_t    mem_q [DEPTH];
   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == CNT_FULL);
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Pointer wrap and occupancy update
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
      if (do_pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state; cleared on reset so in-flight entries are dropped
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/sram_like_slave.sv
// sram_like_slave: SRAM-style slave. Requests are queued in order and each
// completes LATENCY cycles after becoming queue head; memory is accessed
// on the completing (pop) cycle.
// Optional build macro: SRAM_SLAVE_RANDOM_STALL_EN adds an LFSR that
// randomly refuses acceptance.
module sram_like_slave
   import sram_like_pkg::*;
#(
   parameter int MEM_AW  = 12,
   parameter int LATENCY = 2,
   parameter int QDEPTH  = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        addr_ok,
   output logic        data_ok
);

   localparam int         WORDS    = 1 << MEM_AW;
   localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

   req_entry_t        push_ent;
   req_entry_t        head;
   logic              q_full, q_empty;
   logic              stall;
   logic              pop;
   logic [3:0]        lat_q, lat_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       mem_q [WORDS];
   logic [MEM_AW-1:0] idx;
   logic [31:0]       rd_word;
   logic [3:0]        be;
   logic              unused_addr_hi;

`ifdef SRAM_SLAVE_RANDOM_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign stall  = lfsr_q[0];

   // Free-running stall generator
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) lfsr_q <= 16'hACE1;
      else         lfsr_q <= lfsr_d;
   end
`else
   assign stall = 1'b0;
`endif

   // full is the registered occupancy, so a pop this cycle never frees room
   // for a push this cycle; resetn gating keeps addr_ok low during reset
   assign addr_ok  = req & ~q_full & resetn & ~stall;
   assign push_ent = '{wr: wr, size: size, addr: addr, wdata: wdata};

   req_fifo #(.DEPTH(QDEPTH)) u_req_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (addr_ok),
      .pop_i   (pop),
      .din_i   (push_ent),
      .full_o  (q_full),
      .empty_o (q_empty),
      .head_o  (head)
   );

   assign data_ok = ~q_empty & (lat_q == LAT_LAST);
   assign pop     = data_ok;

   assign idx            = head.addr[MEM_AW+1:2];
   assign rd_word        = mem_q[idx];
   assign be             = byte_en(head.size, head.addr[1:0]);
   assign unused_addr_hi = ^head.addr[31:MEM_AW+2];

   // Read data appears with data_ok and is held until the next read completes
   assign rdata   = (pop & ~head.wr) ? rd_word : rdata_q;
   assign rdata_d = rdata;

   // Head latency count: restarts whenever a new entry becomes head
   always_comb begin
      lat_d = lat_q;
      if (q_empty || pop) lat_d = '0;
      else                lat_d = lat_q + 4'd1;
   end

   // Latency counter and held read data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lat_q   <= '0;
         rdata_q <= '0;
      end else begin
         lat_q   <= lat_d;
         rdata_q <= rdata_d;
      end
   end

   // Memory array, deliberately not reset; writes commit on the pop cycle
   always_ff @(posedge clk) begin
      if (pop && head.wr) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem_q[idx][8*b +: 8] <= head.wdata[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_sram_like_slave.sv
// tb_sram_like_slave: cycle-exact vector table for the directed cases, a
// reset-while-busy sequence and a randomized run, all cross-checked by a
// transaction-level model (in-order queue plus byte-lane memory image).
module tb_sram_like_slave;

   localparam int LAT = 2;
   localparam int QD  = 2;
   localparam int AW  = 12;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        req = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  size = 2'd0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        addr_ok, data_ok;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_like_slave #(.MEM_AW(AW), .LATENCY(LAT), .QDEPTH(QD)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .req     (req),
      .wr      (wr),
      .size    (size),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .addr_ok (addr_ok),
      .data_ok (data_ok)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit        wr;
      bit [1:0]  size;
      bit [31:0] addr;
      bit [31:0] wdata;
   } txn_t;

   txn_t        pend[$];
   bit [31:0]   mm [1 << AW];
   bit [3:0]    kn [1 << AW];
   logic [31:0] last_rd = '0;
   int          n_acc = 0;
   int          n_stall = 0;

   function automatic bit [3:0] lanes(input bit [1:0] s, input bit [1:0] off);
      int nb;
      int st;
      nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
      st = int'(off) - (int'(off) % nb);
      return 4'(((1 << nb) - 1) << st);
   endfunction

   always @(negedge clk) begin
      txn_t        t;
      bit [AW-1:0] ix;
      bit [3:0]    m;
      bit [31:0]   m32;
      if (!resetn) begin
         chk("rst_data_ok", {31'b0, data_ok}, 32'd0);
         chk("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
         chk("rst_rdata", rdata, 32'd0);
         pend.delete();
         last_rd = '0;
      end else begin
         if (data_ok) begin
            if (pend.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_data_ok: got 1 expected 0 (no pending request)");
            end else begin
               t  = pend.pop_front();
               ix = t.addr[AW+1:2];
               if (t.wr) begin
                  m = lanes(t.size, t.addr[1:0]);
                  for (int b = 0; b < 4; b++)
                     if (m[b]) mm[ix][8*b +: 8] = t.wdata[8*b +: 8];
                  kn[ix] = kn[ix] | m;
                  chk("wr_ack_rdata_held", rdata, last_rd);
               end else begin
                  for (int b = 0; b < 4; b++) m32[8*b +: 8] = {8{kn[ix][b]}};
                  chk($sformatf("rd_data@%h", t.addr), rdata & m32, mm[ix] & m32);
                  last_rd = rdata;
               end
            end
         end
         if (req && addr_ok) begin
            t = '{wr: wr, size: size, addr: addr, wdata: wdata};
            pend.push_back(t);
            n_acc++;
         end
         if (req && !addr_ok) n_stall++;
      end
   end

   // ---------------- directed vector table ----------------
   typedef struct {
      bit        rq;
      bit        w;
      bit [1:0]  s;
      bit [31:0] a;
      bit [31:0] d;
      bit        ao;
      bit        dok;
      bit        cr;
      bit [31:0] rd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(input bit rq, input bit w, input bit [1:0] s, input bit [31:0] a,
                              input bit [31:0] d, input bit ao, input bit dok, input bit cr,
                              input bit [31:0] rd);
      vec_t v;
      v = '{rq: rq, w: w, s: s, a: a, d: d, ao: ao, dok: dok, cr: cr, rd: rd};
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int acc0, stall0, cyc;
      bit [1:0] off;
      // word write/read, byte lane write, back-pressure, aliasing, halfword, size 3
      tbl.push_back(V(1,1,2,32'h100, 32'hDEADBEEF, 1,0,0,0));          // 0
      tbl.push_back(V(1,0,2,32'h100, 0,            1,0,0,0));          // 1
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'h0));      // 2 write ack
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 3
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hDEADBEEF));// 4
      tbl.push_back(V(1,1,2,32'h200, 32'h11223344, 1,0,0,0));          // 5
      tbl.push_back(V(1,1,0,32'h202, 32'h005A0000, 1,0,0,0));          // 6
      tbl.push_back(V(1,0,2,32'h200, 0,            0,1,1,32'hDEADBEEF));// 7 full
      tbl.push_back(V(1,0,2,32'h200, 0,            1,0,0,0));          // 8
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hDEADBEEF));// 9
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 10
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'h115A3344));// 11
      tbl.push_back(V(1,0,2,32'h100, 0,            1,0,0,0));          // 12
      tbl.push_back(V(1,0,2,32'h200, 0,            1,0,0,0));          // 13
      tbl.push_back(V(1,0,2,32'h4100,0,            0,1,1,32'hDEADBEEF));// 14 full
      tbl.push_back(V(1,0,2,32'h4100,0,            1,0,0,0));          // 15
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'h115A3344));// 16
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 17
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hDEADBEEF));// 18 alias
      tbl.push_back(V(1,1,2,32'h4000,32'hCAFEF00D, 1,0,0,0));          // 19
      tbl.push_back(V(1,0,2,32'h0,   0,            1,0,0,0));          // 20
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hDEADBEEF));// 21
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 22
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hCAFEF00D));// 23 alias
      tbl.push_back(V(1,1,1,32'h102, 32'hABCD0000, 1,0,0,0));          // 24
      tbl.push_back(V(1,0,2,32'h100, 0,            1,0,0,0));          // 25
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hCAFEF00D));// 26
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 27
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hABCDBEEF));// 28
      tbl.push_back(V(1,1,3,32'h300, 32'h01020304, 1,0,0,0));          // 29
      tbl.push_back(V(1,0,2,32'h300, 0,            1,0,0,0));          // 30
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'hABCDBEEF));// 31
      tbl.push_back(V(0,0,0,0,       0,            0,0,0,0));          // 32
      tbl.push_back(V(0,0,0,0,       0,            0,1,1,32'h01020304));// 33

      // reset with a pending request driven: addr_ok must stay low
      resetn = 1'b0;
      req    = 1'b1;
      repeat (3) tick();
      resetn = 1'b1;
      req    = 1'b0;

`ifndef SRAM_SLAVE_RANDOM_STALL_EN
      foreach (tbl[i]) begin
         req = tbl[i].rq; wr = tbl[i].w; size = tbl[i].s; addr = tbl[i].a; wdata = tbl[i].d;
         @(negedge clk);
         chk($sformatf("v%0d_addr_ok", i), {31'b0, addr_ok}, {31'b0, tbl[i].ao});
         chk($sformatf("v%0d_data_ok", i), {31'b0, data_ok}, {31'b0, tbl[i].dok});
         if (tbl[i].cr) chk($sformatf("v%0d_rdata", i), rdata, tbl[i].rd);
         tick();
      end

      // reset while two entries are queued: no completion, empty afterwards
      req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
      tick();
      addr = 32'h200;
      tick();
      req = 1'b0;
      resetn = 1'b0;
      req = 1'b1;
      repeat (3) tick();
      resetn = 1'b1;
      req = 1'b0;
      for (int c = 0; c < LAT + 3; c++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_data_ok", c), {31'b0, data_ok}, 32'd0);
         chk($sformatf("post_rst%0d_addr_ok", c), {31'b0, addr_ok}, {31'b0, req});
         tick();
      end
      req = 1'b1; addr = 32'h200;
      @(negedge clk);
      chk("post_rst_addr_ok_eq_req", {31'b0, addr_ok}, {31'b0, req});
      tick();
      req = 1'b0;
      repeat (LAT + 2) tick();
      chk("post_rst_queue_empty", pend.size(), 32'd0);
`endif

      // randomized traffic; the model checks order and data
      acc0   = n_acc;
      stall0 = n_stall;
      cyc    = 0;
      while ((n_acc - acc0) < 100 && cyc < 5000) begin
         req   = ($urandom_range(0, 9) < 7);
         wr    = 1'($urandom_range(0, 1));
         size  = 2'($urandom_range(0, 3));
         off   = 2'($urandom_range(0, 3));
         addr  = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(64, 79)) << 2) | 32'(off);
         wdata = $urandom;
         tick();
         cyc++;
      end
      req = 1'b0;
      chk("random_accepted_100", {31'b0, ((n_acc - acc0) >= 100)}, 32'd1);
      cyc = 0;
      while (pend.size() != 0 && cyc < 500) begin
         tick();
         cyc++;
      end
      chk("random_drained", pend.size(), 32'd0);
      chk("random_addr_ok_low_seen", {31'b0, (n_stall > stall0)}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
